// File: rtl/seven_seg_scan_pkg.sv
// Shared types, glyph table and helpers for the seven-segment scan display.
package seven_seg_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_COMMIT
    } conv_state_e;

    localparam logic [7:0] CATHODE_DASH  = 8'hBF;
    localparam logic [7:0] CATHODE_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for 0..F; dp is always off.
    localparam logic [7:0] GLYPHS [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    function automatic logic [7:0] seg_decode(digit_t d);
        return GLYPHS[d];
    endfunction

    // Cycles spent on each digit slot; never below 2 so the counter has room to count.
    function automatic int digit_ticks(int clk_per, int refr_rate);
        longint t;
        t = 64'd1_000_000_000 / (longint'(clk_per) * longint'(refr_rate));
        return (t < 2) ? 2 : int'(t);
    endfunction

    function automatic logic [63:0] pow10(int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Load/display bundle between a value producer and the scan display.
interface seven_seg_scan_if #(
    parameter int NUM_SEGMENTS = 4
);
    localparam int W = 4 * NUM_SEGMENTS;

    logic [W-1:0]            value;
    logic                    value_valid;
    logic                    busy;
    logic [NUM_SEGMENTS-1:0] anode;
    logic [7:0]              cathode;

    modport master (output value, value_valid, input busy, anode, cathode);
    modport slave  (input value, value_valid, output busy, anode, cathode);
endinterface

// File: rtl/seven_seg_scan_bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per cycle, W/4 BCD digits out.
module bin2bcd_seq
    import seven_seg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] bcd,
    output logic         overflow
);
    localparam int NDIG = W / 4;
    localparam int CW   = $clog2(W);
    // Values at or above this do not fit in NDIG decimal digits.
    localparam logic [W-1:0] LIMIT = W'(pow10(NDIG));

    conv_state_e   state_q;
    logic [W-1:0]  bin_q;
    logic [W-1:0]  bcd_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next bit.
    function automatic logic [W-1:0] dabble(logic [W-1:0] b, logic in_bit);
        logic [W-1:0] adj;
        for (int i = 0; i < NDIG; i++)
            adj[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return {adj[W-2:0], in_bit};
    endfunction

    // IDLE -> CONV (W cycles) -> COMMIT (1 cycle) -> IDLE, or straight back to CONV on start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_COMMIT: begin
                    if (start) begin
                        state_q <= ST_CONV;
                        bin_q   <= bin;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= (bin >= LIMIT);
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_CONV: begin
                    bcd_q <= dabble(bcd_q, bin_q[W-1]);
                    bin_q <= bin_q << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_q <= ST_COMMIT;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/seven_seg_scan.sv
// Hex/decimal display back-end that time-multiplexes digits onto a common-anode bank.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter     MODE         = "HEX",
    parameter int NUM_SEGMENTS = 4,
    parameter int CLK_PER      = 10,
    parameter int REFR_RATE    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    seven_seg_scan_if.slave  bus
);
    localparam int W     = 4 * NUM_SEGMENTS;
    localparam int TICKS = digit_ticks(CLK_PER, REFR_RATE);
    localparam int TW    = $clog2(TICKS);
    localparam int IW    = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1;

    logic [TW-1:0]               tick_q;
    logic [IW-1:0]               idx_q;
    logic [NUM_SEGMENTS-1:0]     anode_q;
    logic [7:0]                  cathode_q;
    digit_t [NUM_SEGMENTS-1:0]   disp_q, disp_d;
    logic                        dash_q, dash_d;

    if (MODE == "DEC") begin : g_dec
        logic         conv_start, conv_busy, conv_done, conv_ovf;
        logic [W-1:0] conv_bin, conv_bcd;
        logic [W-1:0] pend_q, pend_d;
        logic         pend_vld_q, pend_vld_d;

        bin2bcd_seq #(.W(W)) u_conv (
            .clk      (clk),
            .rst      (rst),
            .start    (conv_start),
            .bin      (conv_bin),
            .busy     (conv_busy),
            .done     (conv_done),
            .bcd      (conv_bcd),
            .overflow (conv_ovf)
        );

        // Commit finished conversions; start from pending first, else from a fresh load.
        always_comb begin
            disp_d     = disp_q;
            dash_d     = dash_q;
            pend_d     = pend_q;
            pend_vld_d = pend_vld_q;
            conv_start = 1'b0;
            conv_bin   = bus.value;
            if (conv_done) begin
                disp_d = conv_bcd;
                dash_d = conv_ovf;
            end
            if (!conv_busy || conv_done) begin
                if (pend_vld_q) begin
                    conv_start = 1'b1;
                    conv_bin   = pend_q;
                    pend_vld_d = bus.value_valid;
                    if (bus.value_valid) pend_d = bus.value;
                end else if (bus.value_valid) begin
                    conv_start = 1'b1;
                end
            end else if (bus.value_valid) begin
                pend_d     = bus.value;
                pend_vld_d = 1'b1;
            end
        end

        // One-deep pending buffer; newest load wins.
        always_ff @(posedge clk) begin
            if (rst) begin
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
            end else begin
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
            end
        end

        assign bus.busy = conv_busy;
    end else begin : g_hex
        // Raw nibbles go straight into the display register.
        always_comb begin
            disp_d = disp_q;
            dash_d = 1'b0;
            if (bus.value_valid) disp_d = bus.value;
        end

        assign bus.busy = 1'b0;
    end

    // Display register holding the digits currently being scanned out.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_q <= '0;
            dash_q <= 1'b0;
        end else begin
            disp_q <= disp_d;
            dash_q <= dash_d;
        end
    end

    // Slot timer, digit index and registered anode/cathode drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= CATHODE_BLANK;
        end else begin
            if (tick_q == TW'(TICKS - 1)) begin
                tick_q <= '0;
                idx_q  <= (idx_q == IW'(NUM_SEGMENTS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                tick_q <= tick_q + TW'(1);
            end
            anode_q   <= ~(NUM_SEGMENTS'(1) << idx_q);
            cathode_q <= dash_q ? CATHODE_DASH : seg_decode(disp_q[idx_q]);
        end
    end

    assign bus.anode   = anode_q;
    assign bus.cathode = cathode_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: one HEX and one DEC instance against a timeline model.
module tb_seven_seg_scan;
    localparam int N = 4;

    typedef struct {
        int               at;
        logic [3:0][7:0]  g;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   since_rst = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [3:0][7:0] hex_g, dec_g;
    upd_t qh[$], qd[$];
    int   conv_end = -1000;
    int   busy_start = -1000;
    bit   pend_v = 1'b0;
    int   pend_val = 0;
    int   seven_seen = 0;

    seven_seg_scan_if #(.NUM_SEGMENTS(N)) hif ();
    seven_seg_scan_if #(.NUM_SEGMENTS(N)) dif ();

    seven_seg_scan #(.MODE("HEX"), .NUM_SEGMENTS(N), .CLK_PER(10), .REFR_RATE(25_000_000))
        u_hex (.clk(clk), .rst(rst), .bus(hif));
    seven_seg_scan #(.MODE("DEC"), .NUM_SEGMENTS(N), .CLK_PER(10), .REFR_RATE(25_000_000))
        u_dec (.clk(clk), .rst(rst), .bus(dif));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        since_rst <= rst ? 0 : since_rst + 1;
    end

    function automatic logic [7:0] glyph(int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90; 10: return 8'h88; 11: return 8'h83;
           12: return 8'hC6; 13: return 8'hA1; 14: return 8'h86; 15: return 8'h8E;
            default: return 8'hBF;
        endcase
    endfunction

    function automatic logic [3:0][7:0] hex_glyphs(int v);
        logic [3:0][7:0] g;
        for (int i = 0; i < 4; i++) g[i] = glyph((v >> (4 * i)) % 16);
        return g;
    endfunction

    function automatic logic [3:0][7:0] dec_glyphs(int v);
        logic [3:0][7:0] g;
        int p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            g[i] = (v >= 10000) ? 8'hBF : glyph((v / p) % 10);
            p = p * 10;
        end
        return g;
    endfunction

    function automatic logic [3:0] exp_anode();
        if (since_rst == 0) return 4'hF;
        return ~(4'b0001 << (((since_rst - 1) / 4) % 4));
    endfunction

    function automatic logic [7:0] exp_cath(bit dec);
        int idx;
        if (since_rst == 0) return 8'hFF;
        idx = ((since_rst - 1) / 4) % 4;
        return dec ? dec_g[idx] : hex_g[idx];
    endfunction

    function automatic logic exp_busy();
        return (since_rst > 0) && (cyc >= busy_start) && (cyc <= conv_end);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hex_g[i] = 8'hC0;
            dec_g[i] = 8'hC0;
        end
        qh.delete();
        qd.delete();
        conv_end   = -1000;
        busy_start = -1000;
        pend_v     = 1'b0;
    endtask

    // A conversion accepted in cycle c shows its result from c+19 and is busy through c+17.
    task automatic start_conv(int v, int c);
        upd_t u;
        u.at = c + 19;
        u.g  = dec_glyphs(v);
        qd.push_back(u);
        conv_end = c + 17;
    endtask

    task automatic cycle_step();
        @(negedge clk);
        hif.value_valid = 1'b0;
        dif.value_valid = 1'b0;
        while (qh.size() > 0 && qh[0].at <= cyc) begin
            hex_g = qh[0].g;
            void'(qh.pop_front());
        end
        while (qd.size() > 0 && qd[0].at <= cyc) begin
            dec_g = qd[0].g;
            void'(qd.pop_front());
        end
        if (pend_v && cyc == conv_end) begin
            start_conv(pend_val, cyc);
            pend_v = 1'b0;
        end
    endtask

    task automatic drive_hex(int v);
        upd_t u;
        hif.value       = 16'(v);
        hif.value_valid = 1'b1;
        u.at = cyc + 2;
        u.g  = hex_glyphs(v);
        qh.push_back(u);
    endtask

    task automatic drive_dec(int v);
        dif.value       = 16'(v);
        dif.value_valid = 1'b1;
        if (cyc > conv_end) begin
            busy_start = cyc + 1;
            start_conv(v, cyc);
        end else if (cyc == conv_end && !pend_v) begin
            start_conv(v, cyc);
        end else begin
            pend_v   = 1'b1;
            pend_val = v;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 24; c++) begin
            cycle_step();
            tests_run++;
            if ({hif.busy, hif.anode, hif.cathode} !== {1'b0, exp_anode(), exp_cath(0)}) begin
                tests_failed++;
                $display("FAIL reset_hex cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         hif.busy, hif.anode, hif.cathode, 1'b0, exp_anode(), exp_cath(0));
            end
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL reset_dec cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            if (c == 2) rst = 1'b0;
        end
    endtask

    task automatic test_hex_load();
        for (int c = 0; c < 22; c++) begin
            cycle_step();
            tests_run++;
            if ({hif.busy, hif.anode, hif.cathode} !== {1'b0, exp_anode(), exp_cath(0)}) begin
                tests_failed++;
                $display("FAIL hex_load cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         hif.busy, hif.anode, hif.cathode, 1'b0, exp_anode(), exp_cath(0));
            end
            if (c == 0) drive_hex(16'hA5F3);
        end
    endtask

    task automatic test_hex_random();
        for (int c = 0; c < 80; c++) begin
            cycle_step();
            tests_run++;
            if ({hif.busy, hif.anode, hif.cathode} !== {1'b0, exp_anode(), exp_cath(0)}) begin
                tests_failed++;
                $display("FAIL hex_random cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         hif.busy, hif.anode, hif.cathode, 1'b0, exp_anode(), exp_cath(0));
            end
            if ($urandom_range(0, 5) == 0) drive_hex(int'($urandom_range(0, 65535)));
        end
    endtask

    task automatic test_dec_load();
        for (int c = 0; c < 40; c++) begin
            cycle_step();
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL dec_load cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            if (c == 0) drive_dec(1234);
        end
    endtask

    task automatic test_dec_overflow();
        for (int c = 0; c < 80; c++) begin
            cycle_step();
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL dec_overflow cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            if (c == 0)  drive_dec(10000);
            if (c == 40) drive_dec(9999);
        end
    endtask

    task automatic test_back_to_back();
        seven_seen = 0;
        for (int c = 0; c < 60; c++) begin
            cycle_step();
            if (dif.cathode === 8'hF8) seven_seen++;
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL back_to_back cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            if (c == 0) drive_dec(42);
            if (c == 3) drive_dec(7);
            if (c == 8) drive_dec(9);
        end
        tests_run++;
        if (seven_seen !== 0) begin
            tests_failed++;
            $display("FAIL back_to_back_no7 got %0d cycles showing 7, exp 0", seven_seen);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 50; c++) begin
            cycle_step();
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL reset_mid cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            if (c == 0) drive_dec(int'($urandom_range(1, 9999)));
            if (c == 2) drive_dec(int'($urandom_range(1, 9999)));
            if (c == 5) begin
                rst = 1'b1;
                model_reset();
            end
            if (c == 7) rst = 1'b0;
        end
    endtask

    task automatic test_random_dec();
        for (int c = 0; c < 400; c++) begin
            cycle_step();
            tests_run++;
            if ({dif.busy, dif.anode, dif.cathode} !== {exp_busy(), exp_anode(), exp_cath(1)}) begin
                tests_failed++;
                $display("FAIL random_dec cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         dif.busy, dif.anode, dif.cathode, exp_busy(), exp_anode(), exp_cath(1));
            end
            tests_run++;
            if ({hif.busy, hif.anode, hif.cathode} !== {1'b0, exp_anode(), exp_cath(0)}) begin
                tests_failed++;
                $display("FAIL random_hex cyc=%0d got busy/an/cat %b/%b/%h exp %b/%b/%h", cyc,
                         hif.busy, hif.anode, hif.cathode, 1'b0, exp_anode(), exp_cath(0));
            end
            if ($urandom_range(0, 11) == 0)
                drive_dec($urandom_range(0, 1) ? int'($urandom_range(0, 65535))
                                               : int'($urandom_range(0, 9999)));
            if ($urandom_range(0, 15) == 0) drive_hex(int'($urandom_range(0, 65535)));
        end
    endtask

    initial begin
        hif.value       = '0;
        hif.value_valid = 1'b0;
        dif.value       = '0;
        dif.value_valid = 1'b0;
        test_reset();
        test_hex_load();
        test_hex_random();
        test_dec_load();
        test_dec_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random_dec();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Display back-end for the button-count designs: accepts a 4·NUM_SEGMENTS-bit binary value with a load strobe, converts it to hex or decimal digits, and time-multiplexes the digits onto one common-anode 7-segment display bank. Sits directly downstream of the press counter, one instance per display. Decimal mode uses a sequential binary-to-BCD converter, so loads are accepted with a busy window and one-deep pending buffering.

## Interface
- MODE, "HEX", "HEX" shows raw nibbles; "DEC" shows the value in decimal
- NUM_SEGMENTS, 4, number of digits; input width W = 4·NUM_SEGMENTS
- CLK_PER, 10, clock period in ns
- REFR_RATE, 1000, per-digit refresh rate in Hz; DIGIT_TICKS = 10^9/(CLK_PER·REFR_RATE) cycles per digit slot, minimum 2
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- value  in  W  binary value to display
- value_valid  in  1  one-cycle load strobe for value
- busy  out  1  DEC conversion in progress; constant 0 in HEX
- anode  out  NUM_SEGMENTS  digit enables, active low; bit 0 = rightmost digit
- cathode  out  8  segments {dp,g,f,e,d,c,b,a}, active low; dp always 1

## Operation
- Reset values: anode all 1, cathode 8'hFF, busy 0, display register all-zero digits, digit index 0, tick counter 0, pending empty.
- Scan: tick counter counts 0..DIGIT_TICKS-1; at terminal count it clears and the digit index advances, wrapping NUM_SEGMENTS-1 → 0. anode is one-cold at the index.
- Glyphs: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E, dash BF. No leading-zero blanking.
- HEX: value_valid loads value nibbles straight into the display register.
- DEC: value_valid, when idle, captures value and starts the converter. Double-dabble runs one bit per cycle for W cycles: add 3 to each BCD digit ≥ 5, then shift left. The result is committed to the display register.
- Overflow: if captured value ≥ 10^NUM_SEGMENTS, commit all-dash digits instead of the conversion result.
- Load while busy: value goes to a one-deep pending register; the newest load overwrites it. The pending value starts conversion in the cycle after the current commit. Intermediate overwritten values are never displayed.
- Converter states: IDLE → CONV (W cycles) → COMMIT (1 cycle) → IDLE, or → CONV if pending is valid.

## Timing
- anode and cathode are registered from the digit index and display register of the previous cycle.
- First cycle after rst deasserts: anode = digit 0 enabled, cathode = glyph of digit 0 (C0).
- HEX latency: valid in cycle t → display register updated at the end of t → outputs reflect it from t+2.
- DEC latency: valid in cycle t → busy high in cycles t+1..t+W+1 → display register written at the end of t+W+1 → outputs reflect it from t+W+3.
- The scan continues uninterrupted during conversion and shows the old value until commit.
- rst mid-conversion: conversion and pending value are abandoned; all registers return to reset values in the next cycle.

## Structure
- Package seven_seg_pkg:
  - typedef digit_t (4-bit)
  - glyph constants and a digit_t → cathode decode function
  - CATHODE_DASH = 8'hBF, CATHODE_BLANK = 8'hFF
  - function computing DIGIT_TICKS
- Sub-module bin2bcd_seq: parameter W; ports start, bin, busy, done, bcd, overflow; contains the IDLE/CONV/COMMIT FSM. The top level holds the pending register, display register and scan logic.

## Test plan
All scenarios use NUM_SEGMENTS=4, CLK_PER=10, REFR_RATE=25_000_000 (DIGIT_TICKS=4).
- Reset scan: hold rst 3 cycles, release → anode/cathode FF during rst; after release anode 1110, 1101, 1011, 0111 for 4 cycles each, then wraps; cathode C0 throughout.
- HEX load: value 16'hA5F3 → digit0 B0, digit1 8E, digit2 92, digit3 88.
- DEC load: value 16'd1234 → busy high 17 cycles, then digits 99, B0, A4, F9; old digits shown until commit.
- DEC overflow: value 16'd10000 → all digits BF; 16'd9999 → all digits 90.
- DEC back-to-back: load 42, then 7 and 9 during busy → shows 0042, then 0009 after a second conversion; 7 never appears.
- Reset mid-conversion: rst asserted 5 cycles after a DEC load → busy 0 next cycle, display returns to 0000, pending dropped.
